pl_exc_mem_sum: RTL and testbench

Bus-initiator block that drives the data-memory port of the exception pipeline test system: on a start request it reads a run of consecutive words from data memory, accumulates their signed 32-bit sum, and writes the result back to a destination word. Signed overflow aborts the run and raises an overflow flag for the exception logic, with no write-back. It is the master side of the memory's single-port interface: combinational read, write at the clock edge when write-enable is set.

---
 rtl/pl_exc_mem_sum_if.sv | 22 ++
 rtl/pl_exc_mem_sum.sv | 110 +++++++++++
 tb/tb_pl_exc_mem_sum.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pl_exc_mem_sum_if.sv
// Single-port data-memory bus between the summing initiator and the memory.
// Reads are combinational, writes happen at the clock edge while we is high.
interface pl_exc_mem_sum_if;
    logic [31:0] addr;
    logic [31:0] datain;
    logic [31:0] dataout;
    logic        we;

    modport master (
        output addr,
        output datain,
        output we,
        input  dataout
    );

    modport slave (
        input  addr,
        input  datain,
        input  we,
        output dataout
    );
endinterface

// File: rtl/pl_exc_mem_sum.sv
// Memory-summing bus initiator: reads a run of words, accumulates a signed sum,
// writes it back, and aborts with a sticky overflow flag on signed overflow.
module pl_exc_mem_sum #(
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [31:0]        base,
    input  logic [CNT_W-1:0]   count,
    input  logic [31:0]        dest,
    pl_exc_mem_sum_if.master   mem,
    output logic               busy,
    output logic               done,
    output logic               ovr,
    output logic [31:0]        sum
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    logic [1:0]       state;
    logic [29:0]      base_q;
    logic [29:0]      dest_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] idx;
    logic [31:0]      acc;
    logic [31:0]      tmp;
    logic             ovf;
    logic             last;
    logic             unused_bits;

    // Byte-offset bits of the addresses are dropped; words are always aligned.
    assign unused_bits = ^{base[1:0], dest[1:0]};

    always_comb begin
        tmp  = acc + mem.dataout;
        ovf  = (acc[31] == mem.dataout[31]) && (tmp[31] != acc[31]);
        last = (idx + CNT_W'(1)) == cnt_q;
    end

    always_comb begin
        mem.addr   = '0;
        mem.datain = '0;
        mem.we     = 1'b0;
        case (state)
            S_READ:  mem.addr = {base_q, 2'b00} + {{(30-CNT_W){1'b0}}, idx, 2'b00};
            S_WRITE: begin
                mem.addr   = {dest_q, 2'b00};
                mem.datain = acc;
                mem.we     = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_FIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            base_q <= '0;
            dest_q <= '0;
            cnt_q  <= '0;
            idx    <= '0;
            acc    <= '0;
            ovr    <= 1'b0;
            sum    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q <= base[31:2];
                        dest_q <= dest[31:2];
                        cnt_q  <= count;
                        idx    <= '0;
                        acc    <= '0;
                        ovr    <= 1'b0;
                        sum    <= '0;
                        state  <= (count != '0) ? S_READ : S_WRITE;
                    end
                end
                S_READ: begin
                    // On overflow the accumulator keeps its last good value.
                    if (ovf) begin
                        ovr   <= 1'b1;
                        state <= S_FIN;
                    end else begin
                        acc <= tmp;
                        idx <= idx + CNT_W'(1);
                        if (last) state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    sum   <= acc;
                    state <= S_FIN;
                end
                S_FIN: begin
                    if (ovr) sum <= acc;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pl_exc_mem_sum.sv
// Scoreboard bench for pl_exc_mem_sum: stimulus pushes expected bus events,
// a negedge monitor pops and compares every read, write and done it observes.
module tb_pl_exc_mem_sum;

    localparam int CNT_W = 6;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
        logic        ovr;
    } item_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic [31:0]      base;
    logic [CNT_W-1:0] count;
    logic [31:0]      dest;
    logic             busy;
    logic             done;
    logic             ovr;
    logic [31:0]      sum;

    logic [31:0] mem [0:63];
    logic        ldEn;
    logic [31:0] ldAddr;
    logic [31:0] ldData;

    int    cyc;
    int    checks;
    int    errors;
    item_t sb[$];

    logic        pendSum;
    logic [31:0] pendSumVal;
    logic        pendOvrVal;

    pl_exc_mem_sum_if bus ();

    pl_exc_mem_sum #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .base  (base),
        .count (count),
        .dest  (dest),
        .mem   (bus),
        .busy  (busy),
        .done  (done),
        .ovr   (ovr),
        .sum   (sum)
    );

    // 256-byte memory model; addresses alias modulo 256 so 0xfffffffc lands at word 63.
    assign bus.dataout = mem[bus.addr[7:2]];

    always @(posedge clk) begin
        if (bus.we) mem[bus.addr[7:2]] <= bus.datain;
        else if (ldEn) mem[ldAddr[7:2]] <= ldData;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pushItem(input int kind, input int c, input logic [31:0] a,
                            input logic [31:0] d, input logic o);
        item_t it;
        it.kind = kind;
        it.cyc  = c;
        it.addr = a;
        it.data = d;
        it.ovr  = o;
        sb.push_back(it);
    endtask

    // Reads land on cycles k..k+n-1, write on k+n, done on k+n+1; overflow on read i gives done at k+i+1.
    task automatic expectRun(input logic [31:0] b, input int n, input logic [31:0] d,
                             input logic [31:0] expSum, input int ovrIdx, input int k);
        int nr;
        nr = (ovrIdx >= 0) ? ovrIdx + 1 : n;
        for (int i = 0; i < nr; i++) pushItem(0, k + i, b + 32'(4 * i), 32'h0, 1'b0);
        if (ovrIdx < 0) begin
            pushItem(1, k + n, d, expSum, 1'b0);
            pushItem(2, k + n + 1, 32'h0, expSum, 1'b0);
        end else begin
            pushItem(2, k + ovrIdx + 1, 32'h0, expSum, 1'b1);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] b, input int n, input logic [31:0] d, input int lead);
        start = 1'b1;
        base  = b;
        count = CNT_W'(n);
        dest  = d;
        repeat (lead + 1) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        base  = 32'hdead_beef;
        count = '1;
        dest  = 32'hcafe_f00c;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        ldEn   = 1'b1;
        ldAddr = a;
        ldData = d;
        @(negedge clk);
        ldEn   = 1'b0;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_addr"},   bus.addr,   32'h0);
        checkOutput({tag, "_datain"}, bus.datain, 32'h0);
        checkOutput({tag, "_we"},     32'(bus.we), 32'h0);
        checkOutput({tag, "_busy"},   32'(busy),   32'h0);
        checkOutput({tag, "_done"},   32'(done),   32'h0);
        checkOutput({tag, "_ovr"},    32'(ovr),    32'h0);
        checkOutput({tag, "_sum"},    sum,         32'h0);
    endtask

    // Monitor: classify each cycle's bus activity and compare it with the queue head.
    initial begin
        int kind;
        item_t it;
        pendSum = 1'b0;
        forever begin
            @(negedge clk);
            if (pendSum) begin
                checkOutput("sum_after_done", sum, pendSumVal);
                checkOutput("ovr_after_done", 32'(ovr), 32'(pendOvrVal));
                pendSum = 1'b0;
            end
            kind = -1;
            if (done === 1'b1) kind = 2;
            else if (bus.we === 1'b1) kind = 1;
            else if (busy === 1'b1) kind = 0;
            if (kind >= 0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_event: got kind %0d addr %h expected none (cycle %0d)",
                             kind, bus.addr, cyc);
                end else begin
                    it = sb.pop_front();
                    checkOutput("evt_kind", 32'(kind), 32'(it.kind));
                    checkOutput("evt_cycle", 32'(cyc), 32'(it.cyc));
                    if (it.kind == 0) checkOutput("rd_addr", bus.addr, it.addr);
                    if (it.kind == 1) begin
                        checkOutput("wr_addr", bus.addr, it.addr);
                        checkOutput("wr_data", bus.datain, it.data);
                    end
                    if (it.kind == 2) begin
                        pendSum    = 1'b1;
                        pendSumVal = it.data;
                        pendOvrVal = it.ovr;
                    end
                end
            end
        end
    end

    initial begin
        int k;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        base   = '0;
        count  = '0;
        dest   = '0;
        ldEn   = 1'b0;
        ldAddr = '0;
        ldData = '0;
        repeat (2) @(negedge clk);
        checkIdle("reset");
        rst = 1'b0;

        preload(32'h50, 32'ha3);
        preload(32'h54, 32'h27);
        preload(32'h58, 32'h79);
        preload(32'h5c, 32'h115);
        preload(32'h60, 32'h0);
        preload(32'h48, 32'h2);
        preload(32'h4c, 32'h7fff_ffff);
        preload(32'h70, 32'h0bad_f00d);
        preload(32'h64, 32'hdead_beef);
        preload(32'hfc, 32'h1111_1111);
        preload(32'h00, 32'h2222_2222);
        preload(32'h68, 32'h0);
        preload(32'h6c, 32'h0);
        preload(32'h74, 32'hffff_ffff);
        preload(32'h78, 32'h1234_5678);

        $display("[TB] run: four-word sum");
        k = cyc + 1;
        expectRun(32'h50, 4, 32'h60, 32'h258, -1, k);
        applyStimulus(32'h50, 4, 32'h60, 0);
        repeat (7) @(negedge clk);
        checkOutput("mem_0x60", mem[6'h18], 32'h258);

        $display("[TB] run: overflow abort");
        k = cyc + 1;
        expectRun(32'h48, 2, 32'h70, 32'h2, 1, k);
        applyStimulus(32'h48, 2, 32'h70, 0);
        repeat (5) @(negedge clk);
        checkOutput("mem_0x70_kept", mem[6'h1c], 32'h0bad_f00d);

        $display("[TB] run: zero count");
        k = cyc + 1;
        expectRun(32'h0, 0, 32'h64, 32'h0, -1, k);
        applyStimulus(32'h0, 0, 32'h64, 0);
        repeat (4) @(negedge clk);
        checkOutput("mem_0x64", mem[6'h19], 32'h0);

        $display("[TB] run: address wrap");
        k = cyc + 1;
        expectRun(32'hffff_fffc, 2, 32'h68, 32'h3333_3333, -1, k);
        applyStimulus(32'hffff_fffc, 2, 32'h68, 0);
        repeat (5) @(negedge clk);
        checkOutput("mem_0x68", mem[6'h1a], 32'h3333_3333);

        $display("[TB] run: start while busy, then back-to-back start");
        k = cyc + 1;
        expectRun(32'h50, 4, 32'h6c, 32'h258, -1, k);
        applyStimulus(32'h50, 4, 32'h6c, 0);
        start = 1'b1;
        base  = 32'h48;
        count = CNT_W'(1);
        dest  = 32'h78;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        k = cyc + 2;
        expectRun(32'h0, 0, 32'h74, 32'h0, -1, k);
        applyStimulus(32'h0, 0, 32'h74, 1);
        repeat (4) @(negedge clk);
        checkOutput("mem_0x6c", mem[6'h1b], 32'h258);
        checkOutput("mem_0x74", mem[6'h1d], 32'h0);
        checkOutput("mem_0x78_kept_a", mem[6'h1e], 32'h1234_5678);

        $display("[TB] run: reset mid-read");
        k = cyc + 1;
        pushItem(0, k, 32'h50, 32'h0, 1'b0);
        pushItem(0, k + 1, 32'h54, 32'h0, 1'b0);
        applyStimulus(32'h50, 4, 32'h78, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkIdle("midrst");
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checkIdle("after_rst");
        checkOutput("mem_0x78_kept_b", mem[6'h1e], 32'h1234_5678);

        checkOutput("sb_empty", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
